// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory responder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } boot_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // True when byteAddr falls inside a 2^aw-word memory (and is word aligned if asked).
    function automatic logic word_index(input logic [31:0] byteAddr,
                                        input int unsigned aw,
                                        input logic needAlign);
        logic inRange;
        logic aligned;
        inRange = ((byteAddr >> (aw + 32'd2)) == 32'd0);
        aligned = (byteAddr[1:0] == 2'b00);
        return inRange && (!needAlign || aligned);
    endfunction

endpackage

// File: rtl/mem_sp_ram.sv
// Word memory with one synchronous write port and one combinational read port.
module mem_sp_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1 << AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the pipelined MIPS core: IMEM/DMEM service,
// boot sequencing (clear DMEM, load IMEM, release core), fault and store tracking.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned IMEM_AW = 10,
    parameter int unsigned DMEM_AW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        pcF,
    output logic [31:0]        instr,
    input  logic [31:0]        alu_outM,
    input  logic [31:0]        write_data,
    input  logic               mem_writeM,
    output logic [31:0]        read_data,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [IMEM_AW-1:0] ld_addr,
    input  logic [31:0]        ld_data,
    input  logic               ld_last,
    output logic               cpu_rst,
    output logic               boot_done,
    output logic               fault,
    output logic [31:0]        fault_addr,
    output logic [31:0]        store_count
);

    boot_state_t          state;
    logic [DMEM_AW-1:0]   clrCnt;
    logic                 inRun;
    logic                 fetchOk;
    logic                 fetchFault;
    logic                 readOk;
    logic                 storeAddrOk;
    logic                 storeOk;
    logic                 storeFault;
    logic                 ldAccept;
    logic [31:0]          imemRd;
    logic [31:0]          dmemRd;
    logic                 dmemWe;
    logic [DMEM_AW-1:0]   dmemWaddr;
    logic [31:0]          dmemWdata;

    assign inRun       = (state == RUN);
    assign boot_done   = inRun;

    assign fetchOk     = word_index(pcF, IMEM_AW, 1'b1);
    assign fetchFault  = inRun && !fetchOk;
    assign readOk      = word_index(alu_outM, DMEM_AW, 1'b0);
    assign storeAddrOk = word_index(alu_outM, DMEM_AW, 1'b1);
    assign storeOk     = inRun && mem_writeM && storeAddrOk;
    assign storeFault  = inRun && mem_writeM && !storeAddrOk;
    assign ldAccept    = ld_valid && ld_ready;

    assign instr       = (inRun && fetchOk) ? imemRd : NOP_INSTR;
    assign read_data   = (inRun && readOk)  ? dmemRd : '0;

    // DMEM write port is owned by the clear sequencer until the core runs.
    always_comb begin
        dmemWe    = 1'b0;
        dmemWaddr = alu_outM[DMEM_AW+1:2];
        dmemWdata = write_data;
        if (state == CLEAR) begin
            dmemWe    = 1'b1;
            dmemWaddr = clrCnt;
            dmemWdata = '0;
        end else if (storeOk) begin
            dmemWe    = 1'b1;
        end
    end

    mem_sp_ram #(
        .WIDTH (32),
        .AW    (IMEM_AW)
    ) u_imem (
        .clk   (clk),
        .we    (ldAccept),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (pcF[IMEM_AW+1:2]),
        .rdata (imemRd)
    );

    mem_sp_ram #(
        .WIDTH (32),
        .AW    (DMEM_AW)
    ) u_dmem (
        .clk   (clk),
        .we    (dmemWe),
        .waddr (dmemWaddr),
        .wdata (dmemWdata),
        .raddr (alu_outM[DMEM_AW+1:2]),
        .rdata (dmemRd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            clrCnt      <= '0;
            ld_ready    <= 1'b0;
            cpu_rst     <= 1'b1;
            fault       <= 1'b0;
            fault_addr  <= '0;
            store_count <= '0;
        end else begin
            cpu_rst <= (state != RUN);
            case (state)
                CLEAR: begin
                    clrCnt <= clrCnt + 1'b1;
                    if (clrCnt == '1) begin
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ldAccept && ld_last) begin
                        state    <= RUN;
                        ld_ready <= 1'b0;
                    end
                end
                RUN: begin
                    // Store faults win over fetch faults when both occur together.
                    if (!fault && (storeFault || fetchFault)) begin
                        fault      <= 1'b1;
                        fault_addr <= storeFault ? alu_outM : pcF;
                    end
                    if (storeOk) begin
                        store_count <= store_count + 32'd1;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized self-checking bench for mips_mem_responder with a behavioural memory model.
module tb_mips_mem_responder;

    localparam int unsigned IAW    = 10;
    localparam int unsigned DAW    = 4;
    localparam int unsigned IDEPTH = 1 << IAW;
    localparam int unsigned DDEPTH = 1 << DAW;
    localparam logic [31:0] IBYTES = 32'(4 * IDEPTH);
    localparam logic [31:0] DBYTES = 32'(4 * DDEPTH);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [31:0]    pcF = '0;
    logic [31:0]    instr;
    logic [31:0]    alu_outM = '0;
    logic [31:0]    write_data = '0;
    logic           mem_writeM = 1'b0;
    logic [31:0]    read_data;
    logic           ld_valid = 1'b0;
    logic           ld_ready;
    logic [IAW-1:0] ld_addr = '0;
    logic [31:0]    ld_data = '0;
    logic           ld_last = 1'b0;
    logic           cpu_rst;
    logic           boot_done;
    logic           fault;
    logic [31:0]    fault_addr;
    logic [31:0]    store_count;

    int unsigned nCompared = 0;
    int unsigned nMismatch = 0;
    logic        checkOn = 1'b0;

    mips_mem_responder #(
        .IMEM_AW (IAW),
        .DMEM_AW (DAW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcF         (pcF),
        .instr       (instr),
        .alu_outM    (alu_outM),
        .write_data  (write_data),
        .mem_writeM  (mem_writeM),
        .read_data   (read_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .cpu_rst     (cpu_rst),
        .boot_done   (boot_done),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .store_count (store_count)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = clearing, 1 = loading, 2 = running.
    int          mPhase = 0;
    int unsigned mClearCycles = 0;
    int unsigned mRunCycles = 0;
    logic        mFault = 1'b0;
    logic [31:0] mFaultAddr = '0;
    logic [31:0] mStores = '0;
    logic [31:0] mImem [IDEPTH];
    logic        mKnown [IDEPTH];
    logic [31:0] mDmem [DDEPTH];

    initial begin
        for (int i = 0; i < int'(IDEPTH); i++) mKnown[i] = 1'b0;
        for (int i = 0; i < int'(DDEPTH); i++) mDmem[i] = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase       = 0;
            mClearCycles = 0;
            mRunCycles   = 0;
            mFault       = 1'b0;
            mFaultAddr   = '0;
            mStores      = '0;
        end else if (mPhase == 0) begin
            mClearCycles++;
            if (mClearCycles == DDEPTH) begin
                mPhase = 1;
                for (int i = 0; i < int'(DDEPTH); i++) mDmem[i] = '0;
            end
        end else if (mPhase == 1) begin
            if (ld_valid) begin
                mImem[ld_addr]  = ld_data;
                mKnown[ld_addr] = 1'b1;
                if (ld_last) begin
                    mPhase     = 2;
                    mRunCycles = 0;
                end
            end
        end else begin
            logic storeBad;
            logic fetchBad;
            storeBad = mem_writeM && !(alu_outM < DBYTES && alu_outM % 4 == 0);
            fetchBad = !(pcF < IBYTES && pcF % 4 == 0);
            if (!mFault && (storeBad || fetchBad)) begin
                mFault     = 1'b1;
                mFaultAddr = storeBad ? alu_outM : pcF;
            end
            if (mem_writeM && !storeBad) begin
                mDmem[alu_outM / 4] = write_data;
                mStores++;
            end
            mRunCycles++;
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            logic running;
            running = (mPhase == 2);
            checkEq("ld_ready", 32'(ld_ready), 32'(mPhase == 1));
            checkEq("boot_done", 32'(boot_done), 32'(running));
            checkEq("cpu_rst", 32'(cpu_rst), 32'(!(running && mRunCycles >= 1)));
            checkEq("fault", 32'(fault), 32'(mFault));
            checkEq("fault_addr", fault_addr, mFaultAddr);
            checkEq("store_count", store_count, mStores);
            if (running && alu_outM < DBYTES)
                checkEq("read_data", read_data, mDmem[alu_outM / 4]);
            else
                checkEq("read_data", read_data, 32'h0);
            if (running && pcF < IBYTES && pcF % 4 == 0) begin
                if (mKnown[pcF / 4]) checkEq("instr", instr, mImem[pcF / 4]);
            end else begin
                checkEq("instr", instr, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        int unsigned n;
        n = $urandom_range(0, 2);
        repeat (n) tick();
    endtask

    task automatic beat(input logic [IAW-1:0] a, input logic [31:0] d, input logic last);
        gap();
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic resetAndBoot();
        mem_writeM = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (DDEPTH) tick();
        for (int i = 0; i < 19; i++)
            beat(IAW'($urandom_range(0, 15)), $urandom, 1'b0);
        beat(IAW'($urandom_range(0, 15)), $urandom, 1'b1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        checkOn = 1'b1;
        repeat (2) tick();
        checkEq("rst cpu_rst", 32'(cpu_rst), 32'h1);
        checkEq("rst boot_done", 32'(boot_done), 32'h0);
        checkEq("rst ld_ready", 32'(ld_ready), 32'h0);
        checkEq("rst fault", 32'(fault), 32'h0);
        checkEq("rst store_count", store_count, 32'h0);

        // Boot with a loader beat offered throughout CLEAR; it must not be taken.
        rst_n    = 1'b1;
        ld_valid = 1'b1;
        ld_addr  = 10'd3;
        ld_data  = 32'h3333_3333;
        ld_last  = 1'b1;
        for (int i = 1; i <= int'(DDEPTH); i++) begin
            tick();
            checkEq("ld_ready rise", 32'(ld_ready), 32'(i == int'(DDEPTH)));
            if (i == int'(DDEPTH) - 1) begin
                ld_valid = 1'b0;
                ld_last  = 1'b0;
            end
        end
        beat(10'd3, 32'h1111_1111, 1'b0);
        beat(10'd0, 32'h2008_0005, 1'b0);
        beat(10'd1, 32'h2009_000C, 1'b0);
        beat(10'd2, 32'hAC09_0004, 1'b0);
        beat(10'd3, 32'h2222_2222, 1'b1);
        checkEq("boot_done after last", 32'(boot_done), 32'h1);
        checkEq("cpu_rst held one run cycle", 32'(cpu_rst), 32'h1);
        tick();
        checkEq("cpu_rst released", 32'(cpu_rst), 32'h0);
        pcF = 32'h0;
        #1 checkEq("instr @0", instr, 32'h2008_0005);
        pcF = 32'hC;
        #1 checkEq("instr @C", instr, 32'h2222_2222);
        pcF = 32'h0;

        // Store then load, with same-cycle read returning old data.
        alu_outM = 32'h4;
        write_data = 32'hDEAD_BEEF;
        mem_writeM = 1'b1;
        #2 checkEq("read during write", read_data, 32'h0);
        tick();
        mem_writeM = 1'b0;
        #1 checkEq("read after write", read_data, 32'hDEAD_BEEF);
        checkEq("store_count 1", store_count, 32'h1);

        alu_outM = 32'h6;
        write_data = 32'h1234_5678;
        mem_writeM = 1'b1;
        tick();
        mem_writeM = 1'b0;
        alu_outM = 32'h4;
        #1 checkEq("misaligned fault", 32'(fault), 32'h1);
        checkEq("misaligned fault_addr", fault_addr, 32'h6);
        checkEq("misaligned count", store_count, 32'h1);
        checkEq("word1 kept", read_data, 32'hDEAD_BEEF);

        alu_outM = 32'h1000;
        mem_writeM = 1'b1;
        tick();
        mem_writeM = 1'b0;
        #1 checkEq("fault_addr sticky", fault_addr, 32'h6);
        checkEq("oor count", store_count, 32'h1);

        // Asynchronous reset between edges, then reboot and check DMEM was re-zeroed.
        alu_outM = 32'h4;
        #2 rst_n = 1'b0;
        #1 checkEq("async cpu_rst", 32'(cpu_rst), 32'h1);
        checkEq("async boot_done", 32'(boot_done), 32'h0);
        checkEq("async fault", 32'(fault), 32'h0);
        tick();
        resetAndBoot();
        tick();
        alu_outM = 32'h4;
        #1 checkEq("dmem rezeroed", read_data, 32'h0);

        pcF = 32'h1000;
        #1 checkEq("oor fetch instr", instr, 32'h0);
        tick();
        pcF = 32'h0;
        #1 checkEq("oor fetch fault", 32'(fault), 32'h1);
        checkEq("oor fetch fault_addr", fault_addr, 32'h1000);

        // Randomized running traffic against the model.
        resetAndBoot();
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            pcF = (r < 97) ? 32'($urandom_range(0, 15) * 4) : $urandom;
            r = $urandom_range(0, 99);
            if (r < 90) alu_outM = 32'($urandom_range(0, 15) * 4);
            else if (r < 95) alu_outM = 32'($urandom_range(0, 63));
            else alu_outM = $urandom;
            write_data = $urandom;
            mem_writeM = ($urandom_range(0, 2) == 0);
            tick();
        end
        mem_writeM = 1'b0;

        // Simultaneous fetch and store faults: store address is recorded.
        resetAndBoot();
        tick();
        pcF = 32'h2000;
        alu_outM = 32'h3;
        mem_writeM = 1'b1;
        tick();
        mem_writeM = 1'b0;
        pcF = 32'h0;
        alu_outM = 32'h0;
        #1 checkEq("priority fault_addr", fault_addr, 32'h3);
        tick();

        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
